// File: rtl/calendar_ctrl.sv
// ---------------------------------------------------------------------------
// calendar_ctrl
//   Calendar date controller. Holds the current day/month/year, advances it
//   by one day per accepted tick, validates loaded dates and computes the
//   day of year with a multi-cycle accumulator (one month length per cycle).
//   ready is high only while IDLE; load/tick are accepted only then.
//
//   Optional feature macro: SYMMETRY_CAL_EN
//     defined   : Gregorian + Symmetry calendars, mode selected by ld_mode.
//     undefined : Gregorian only; ld_mode ignored, cal_mode tied to 0.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   load       in   load request for ld_day/ld_month/ld_year/ld_mode
//   ld_day     in   [5:0]  day to load
//   ld_month   in   [3:0]  month to load
//   ld_year    in   [YEAR_W-1:0] year to load
//   ld_mode    in   0 = Gregorian, 1 = Symmetry
//   tick       in   advance the date by one day
//   ready      out  1 while IDLE
//   day/month/year out current date
//   cal_mode   out  latched calendar mode
//   leap       out  current year is leap in cal_mode
//   doy        out  [8:0] day of year
//   doy_valid  out  doy matches the current date
//   err        out  one-cycle pulse: load rejected
// ---------------------------------------------------------------------------
module calendar_ctrl #(
  parameter int unsigned YEAR_W      = 12,
  parameter int unsigned RESET_YEAR  = 2018,
  parameter int unsigned RESET_MONTH = 1,
  parameter int unsigned RESET_DAY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [5:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic              ld_mode,
  input  logic              tick,
  output logic              ready,
  output logic [5:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              cal_mode,
  output logic              leap,
  output logic [8:0]        doy,
  output logic              doy_valid,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC} state_t;

  state_t            state_q;
  logic [5:0]        day_q;
  logic [3:0]        month_q;
  logic [YEAR_W-1:0] year_q;
  logic [8:0]        acc_q;
  logic [3:0]        idx_q;
  logic [8:0]        doy_q;
  logic              doy_valid_q;
  logic              ready_q;
  logic              err_q;
  logic              cal_mode_q;

  // ---------------------------------------------------------------------
  // Calendar rules
  // ---------------------------------------------------------------------
  function automatic logic greg_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] yv;
    yv = 32'(y);
    return ((yv % 32'd4) == 32'd0) &&
           (((yv % 32'd100) != 32'd0) || ((yv % 32'd400) == 32'd0));
  endfunction

  function automatic logic [5:0] greg_len(input logic [3:0] m, input logic lp);
    logic [5:0] len;
    case (m)
      4'd2:                       len = lp ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:    len = 6'd30;
      default:                    len = 6'd31;
    endcase
    return len;
  endfunction

`ifdef SYMMETRY_CAL_EN
  function automatic logic sym_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] yv;
    yv = 32'(y);
    return (((yv * 32'd52) + 32'd146) % 32'd293) < 32'd52;
  endfunction

  // 28/35/28 quarters; December stretches to 35 in a leap year.
  function automatic logic [5:0] sym_len(input logic [3:0] m, input logic lp);
    logic [5:0] len;
    case (m)
      4'd2, 4'd5, 4'd8, 4'd11: len = 6'd35;
      4'd12:                   len = lp ? 6'd35 : 6'd28;
      default:                 len = 6'd28;
    endcase
    return len;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Combinational helpers: current-year leap flag, month lengths for the
  // tick rollover, the accumulator index and the load validation.
  // ---------------------------------------------------------------------
  logic       leap_cur;
  logic [5:0] cur_len;
  logic [5:0] idx_len;
  logic       ld_leap;
  logic [5:0] ld_len;
  logic       ld_ok;
  logic       ld_mode_eff;

`ifdef SYMMETRY_CAL_EN
  assign ld_mode_eff = ld_mode;
  always_comb begin
    leap_cur = greg_leap(year_q);
    cur_len  = greg_len(month_q, leap_cur);
    idx_len  = greg_len(idx_q, leap_cur);
    if (cal_mode_q) begin
      leap_cur = sym_leap(year_q);
      cur_len  = sym_len(month_q, leap_cur);
      idx_len  = sym_len(idx_q, leap_cur);
    end
    ld_leap = greg_leap(ld_year);
    ld_len  = greg_len(ld_month, ld_leap);
    if (ld_mode_eff) begin
      ld_leap = sym_leap(ld_year);
      ld_len  = sym_len(ld_month, ld_leap);
    end
  end
`else
  // Symmetry loads are validated as Gregorian.
  logic unused_ld_mode;
  assign unused_ld_mode = ld_mode;
  assign ld_mode_eff    = 1'b0;
  always_comb begin
    leap_cur = greg_leap(year_q);
    cur_len  = greg_len(month_q, leap_cur);
    idx_len  = greg_len(idx_q, leap_cur);
    ld_leap  = greg_leap(ld_year);
    ld_len   = greg_len(ld_month, ld_leap);
  end
`endif

  assign ld_ok = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                 (ld_day >= 6'd1) && (ld_day <= ld_len);

  // Next date for an accepted tick; year wraps naturally at 2**YEAR_W.
  logic [5:0]        day_d;
  logic [3:0]        month_d;
  logic [YEAR_W-1:0] year_d;

  always_comb begin
    day_d   = day_q + 6'd1;
    month_d = month_q;
    year_d  = year_q;
    if (day_q == cur_len) begin
      day_d = 6'd1;
      if (month_q == 4'd12) begin
        month_d = 4'd1;
        year_d  = year_q + YEAR_W'(1);
      end else begin
        month_d = month_q + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs.
  // START exists so the accumulator seeds from the registered day after
  // the date has been updated by the accepting edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CALC;
      day_q       <= 6'(RESET_DAY);
      month_q     <= 4'(RESET_MONTH);
      year_q      <= YEAR_W'(RESET_YEAR);
      cal_mode_q  <= 1'b0;
      acc_q       <= 9'(RESET_DAY);
      idx_q       <= 4'd1;
      doy_q       <= 9'd0;
      doy_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            if (ld_ok) begin
              day_q       <= ld_day;
              month_q     <= ld_month;
              year_q      <= ld_year;
              cal_mode_q  <= ld_mode_eff;
              state_q     <= S_START;
              ready_q     <= 1'b0;
              doy_valid_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end else if (tick) begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            state_q     <= S_START;
            ready_q     <= 1'b0;
            doy_valid_q <= 1'b0;
          end
        end
        S_START: begin
          acc_q   <= {3'b000, day_q};
          idx_q   <= 4'd1;
          state_q <= S_CALC;
        end
        S_CALC: begin
          if (idx_q < month_q) begin
            acc_q <= acc_q + {3'b000, idx_len};
            idx_q <= idx_q + 4'd1;
          end else begin
            doy_q       <= acc_q;
            doy_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign leap      = leap_cur;
  assign doy       = doy_q;
  assign doy_valid = doy_valid_q;
  assign err       = err_q;
`ifdef SYMMETRY_CAL_EN
  assign cal_mode  = cal_mode_q;
`else
  logic unused_cal_mode_q;
  assign unused_cal_mode_q = cal_mode_q;
  assign cal_mode  = 1'b0;
`endif

endmodule
